// File: rtl/wombat_register_file_if.sv
// Bus-side port bundle of wombat_register_file (the UART command parser is the master).
interface wombat_register_file_if #(
  parameter int WORD_WIDTH = 8,
  parameter int REG_WIDTH  = 4
);
  logic                            i_w_en;
  logic [WORD_WIDTH-1:0]           i_w_addr;
  logic [WORD_WIDTH*REG_WIDTH-1:0] i_w_value;
  logic [REG_WIDTH-1:0]            i_w_strobe;
  logic                            i_r_en;
  logic [WORD_WIDTH-1:0]           i_r_addr;
  logic [WORD_WIDTH*REG_WIDTH-1:0] o_r_value;
  logic                            o_r_valid;
  logic                            o_r_err;
  logic                            o_w_err;

  modport master (
    output i_w_en, i_w_addr, i_w_value, i_w_strobe, i_r_en, i_r_addr,
    input  o_r_value, o_r_valid, o_r_err, o_w_err
  );

  modport slave (
    input  i_w_en, i_w_addr, i_w_value, i_w_strobe, i_r_en, i_r_addr,
    output o_r_value, o_r_valid, o_r_err, o_w_err
  );
endinterface

// File: rtl/wombat_register_file.sv
// wombat_register_file: parametrised register file with per-register access modes
// (RW / RO / W1C / PULSE), per-word write strobes, hardware status inputs,
// 1- or 2-cycle pipelined reads and out-of-range error flags.
// Optional feature macro: WOMBAT_REGFILE_IRQ_EN (registered OR of all W1C bits on o_irq).

// One register of the file; mode precedence RO > W1C > PULSE > RW is resolved here.
module wombat_register_file_reg #(
  parameter int W        = 32,
  parameter bit IS_RO    = 1'b0,
  parameter bit IS_W1C   = 1'b0,
  parameter bit IS_PULSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] smask,
  input  logic [W-1:0] w_value,
  input  logic         hw_set,
  input  logic [W-1:0] hw_value,
  output logic [W-1:0] q
);
  logic [W-1:0] wdata;
  logic [W-1:0] set_bits;
  // Some modes ignore some inputs; fold them into one sink so that is explicit.
  logic         unused_sink;

  assign wdata       = w_value & smask;
  assign set_bits    = hw_set ? hw_value : '0;
  assign unused_sink = ^{wr, smask, w_value, hw_set, hw_value};

  // Register update according to the access mode of this slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (IS_RO) begin
      if (hw_set) q <= hw_value;
    end else if (IS_W1C) begin
      // hardware set is OR-ed after the clear, so set wins on a shared bit
      q <= (q & ~(wr ? wdata : '0)) | set_bits;
    end else if (IS_PULSE) begin
      q <= wr ? wdata : '0;
    end else if (wr) begin
      q <= (q & ~smask) | wdata;
    end
  end
endmodule

module wombat_register_file #(
  parameter int                   WORD_WIDTH   = 8,
  parameter int                   REG_WIDTH    = 4,
  parameter int                   REG_DEPTH    = 16,
  parameter int                   READ_LATENCY = 1,
  parameter logic [REG_DEPTH-1:0] RO_MASK      = '0,
  parameter logic [REG_DEPTH-1:0] W1C_MASK     = '0,
  parameter logic [REG_DEPTH-1:0] PULSE_MASK   = '0
) (
  input  logic                                             clk,
  input  logic                                             i_reset_n,
  wombat_register_file_if.slave                            bus,
  input  logic [REG_DEPTH-1:0]                             i_hw_set,
  input  logic [REG_DEPTH-1:0][WORD_WIDTH*REG_WIDTH-1:0]   i_hw_value,
  output logic [REG_DEPTH-1:0][WORD_WIDTH*REG_WIDTH-1:0]   o_mem,
  output logic                                             o_irq
);
  localparam int W      = WORD_WIDTH * REG_WIDTH;
  localparam int STAGES = READ_LATENCY - 1;

  logic [W-1:0]           smask;
  logic [REG_DEPTH-1:0]   w_dec;
  logic [W-1:0]           rd_data;
  logic                   r_hit;
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0]        err_pipe;
  logic [STAGES:0][W-1:0] dat_pipe;
  logic                   w_err_q;

  // Expand the per-word strobe into a bit mask.
  for (genvar j = 0; j < REG_WIDTH; j++) begin : g_smask
    assign smask[j*WORD_WIDTH +: WORD_WIDTH] = {WORD_WIDTH{bus.i_w_strobe[j]}};
  end

  // One register slot per address; an out-of-range address matches no slot.
  for (genvar k = 0; k < REG_DEPTH; k++) begin : g_reg
    assign w_dec[k] = bus.i_w_en && (bus.i_w_addr == WORD_WIDTH'(k));
    wombat_register_file_reg #(
      .W(W), .IS_RO(RO_MASK[k]), .IS_W1C(W1C_MASK[k]), .IS_PULSE(PULSE_MASK[k])
    ) u_reg (
      .clk(clk), .rst_n(i_reset_n), .wr(w_dec[k]), .smask(smask),
      .w_value(bus.i_w_value), .hw_set(i_hw_set[k]), .hw_value(i_hw_value[k]),
      .q(o_mem[k])
    );
  end

  // Read mux on the pre-write contents; out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    r_hit   = 1'b0;
    for (int k = 0; k < REG_DEPTH; k++) begin
      if (bus.i_r_addr == WORD_WIDTH'(k)) begin
        rd_data = o_mem[k];
        r_hit   = 1'b1;
      end
    end
  end

  // Read pipeline; stages load only on valid so the last stage holds its data.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= bus.i_r_en;
      if (bus.i_r_en) begin
        dat_pipe[0] <= rd_data;
        err_pipe[0] <= ~r_hit;
      end
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) begin
          dat_pipe[i] <= dat_pipe[i-1];
          err_pipe[i] <= err_pipe[i-1];
        end
      end
    end
  end

  assign bus.o_r_value = dat_pipe[STAGES];
  assign bus.o_r_valid = vld_pipe[STAGES];
  assign bus.o_r_err   = vld_pipe[STAGES] & err_pipe[STAGES];

  // Write error: no slot decoded (out of range) or the slot is read-only.
  always_ff @(posedge clk) begin
    if (!i_reset_n) w_err_q <= 1'b0;
    else            w_err_q <= bus.i_w_en & (~(|w_dec) | (|(w_dec & RO_MASK)));
  end

  assign bus.o_w_err = w_err_q;

`ifdef WOMBAT_REGFILE_IRQ_EN
  localparam logic [REG_DEPTH-1:0] W1C_EFF = W1C_MASK & ~RO_MASK;
  logic irq_any;

  // OR of every bit held in a W1C register.
  always_comb begin
    irq_any = 1'b0;
    for (int k = 0; k < REG_DEPTH; k++) begin
      if (W1C_EFF[k]) irq_any = irq_any | (|o_mem[k]);
    end
  end

  // Registered interrupt, one cycle behind the W1C contents.
  always_ff @(posedge clk) begin
    if (!i_reset_n) o_irq <= 1'b0;
    else            o_irq <= irq_any;
  end
`else
  assign o_irq = 1'b0;
`endif
endmodule

// File: tb/tb_wombat_register_file.sv
// Bench for wombat_register_file: directed table, hand sequences, random run vs. reference model.
module tb_wombat_register_file;
  localparam int WW = 8, RWD = 4, W = 32, D = 16, LAT = 2;
  localparam logic [15:0] RO_M  = 16'h0042;  // regs 1, 6
  localparam logic [15:0] W1C_M = 16'h0148;  // regs 3, 6 (RO wins), 8
  localparam logic [15:0] PUL_M = 16'h0190;  // regs 4, 7, 8 (W1C wins)
`ifdef WOMBAT_REGFILE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [D-1:0]         hw_set;
  logic [D-1:0][W-1:0]  hw_value;
  logic [D-1:0][W-1:0]  mem;
  logic                 irq;

  wombat_register_file_if #(.WORD_WIDTH(WW), .REG_WIDTH(RWD)) bus ();

  wombat_register_file #(
    .WORD_WIDTH(WW), .REG_WIDTH(RWD), .REG_DEPTH(D), .READ_LATENCY(LAT),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M), .PULSE_MASK(PUL_M)
  ) dut (
    .clk(clk), .i_reset_n(rst_n), .bus(bus), .i_hw_set(hw_set),
    .i_hw_value(hw_value), .o_mem(mem), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { int due; logic [W-1:0] d; logic e; } rd_t;
  logic [W-1:0] m_mem [D];
  rd_t          rq [$];
  logic         m_werr, m_irq;
  logic [W-1:0] last_rv;
  int           edge_n;
  int           checks, failures;
  logic [W-1:0] cap [$];
  int           cap_first, cap_last;

  function automatic int mode_of(int k);  // 1=RO 2=W1C 3=PULSE 0=RW
    if (RO_M[k])  return 1;
    if (W1C_M[k]) return 2;
    if (PUL_M[k]) return 3;
    return 0;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.i_w_en = 0; bus.i_w_addr = 0; bus.i_w_value = 0; bus.i_w_strobe = 0;
    bus.i_r_en = 0; bus.i_r_addr = 0; hw_set = 0; hw_value = 0;
  endtask

  // One clock: update the model from the sampled inputs, then compare everything.
  task automatic step();
    logic [W-1:0] nm [D];
    logic [W-1:0] sm, wd;
    int wa, ra;
    bit wr;
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      foreach (m_mem[k]) m_mem[k] = '0;
      rq.delete();
      m_werr = 0; m_irq = 0; last_rv = '0;
    end else begin
      m_irq = 0;
      for (int k = 0; k < D; k++) if (mode_of(k) == 2 && m_mem[k] != 0) m_irq = IRQ_ON;
      ra = int'(bus.i_r_addr);
      wa = int'(bus.i_w_addr);
      if (bus.i_r_en) rq.push_back('{edge_n + LAT - 1, (ra < D) ? m_mem[ra] : '0, ra >= D});
      for (int j = 0; j < RWD; j++) sm[j*WW +: WW] = {WW{bus.i_w_strobe[j]}};
      wd = bus.i_w_value & sm;
      for (int k = 0; k < D; k++) begin
        wr = bus.i_w_en && (wa == k);
        nm[k] = m_mem[k];
        case (mode_of(k))
          1: if (hw_set[k]) nm[k] = hw_value[k];
          2: nm[k] = (m_mem[k] & ~(wr ? wd : '0)) | (hw_set[k] ? hw_value[k] : '0);
          3: nm[k] = wr ? wd : '0;
          default: if (wr) nm[k] = (m_mem[k] & ~sm) | wd;
        endcase
      end
      m_werr = 0;
      if (bus.i_w_en) m_werr = (wa >= D) ? 1'b1 : (mode_of(wa) == 1);
      foreach (m_mem[k]) m_mem[k] = nm[k];
    end
    #1;
    for (int k = 0; k < D; k++) chk($sformatf("mem[%0d]", k), mem[k], m_mem[k]);
    chk("w_err", bus.o_w_err, m_werr);
    chk("irq", irq, m_irq);
    if (rq.size() > 0 && rq[0].due == edge_n) begin
      chk("r_valid", bus.o_r_valid, 1'b1);
      chk("r_value", bus.o_r_value, rq[0].d);
      chk("r_err", bus.o_r_err, rq[0].e);
      last_rv = rq[0].d;
      void'(rq.pop_front());
    end else begin
      chk("r_valid_idle", bus.o_r_valid, 1'b0);
      chk("r_err_idle", bus.o_r_err, 1'b0);
      chk("r_value_hold", bus.o_r_value, last_rv);
    end
    if (bus.o_r_valid) begin
      if (cap.size() == 0) cap_first = edge_n;
      cap_last = edge_n;
      cap.push_back(bus.o_r_value);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit we; logic [7:0] wa; logic [W-1:0] wv; logic [3:0] ws;
    bit re; logic [7:0] ra; int hk; logic [W-1:0] hv;
    int ck; logic [W-1:0] cv; bit cwe; bit crv; logic [W-1:0] crval; bit crerr;
  } vec_t;
  vec_t tbl [25];

  initial begin
    int nv;
    tbl[0]  = '{1, 8'd2,  32'h11223344, 4'hF, 0, 8'd0,  -1, 32'h0,    2, 32'h11223344, 0, 0, 32'h0, 0};
    tbl[1]  = '{1, 8'd2,  32'hAABBCCDD, 4'h5, 0, 8'd0,  -1, 32'h0,    2, 32'h11BB33DD, 0, 0, 32'h0, 0};
    tbl[2]  = '{0, 8'd0,  32'h0,        4'h0, 1, 8'd2,  -1, 32'h0,    2, 32'h11BB33DD, 0, 0, 32'h0, 0};
    tbl[3]  = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,  -1, 32'h0,    2, 32'h11BB33DD, 0, 1, 32'h11BB33DD, 0};
    tbl[4]  = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,   3, 32'hF0,   3, 32'hF0,       0, 0, 32'h0, 0};
    tbl[5]  = '{1, 8'd3,  32'h30,       4'hF, 0, 8'd0,   3, 32'h10,   3, 32'hD0,       0, 0, 32'h0, 0};
    tbl[6]  = '{1, 8'd3,  32'hF0,       4'hF, 0, 8'd0,  -1, 32'h0,    3, 32'h0,        0, 0, 32'h0, 0};
    tbl[7]  = '{1, 8'd1,  32'hDEADBEEF, 4'hF, 0, 8'd0,  -1, 32'h0,    1, 32'h0,        1, 0, 32'h0, 0};
    tbl[8]  = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,  -1, 32'h0,    1, 32'h0,        0, 0, 32'h0, 0};
    tbl[9]  = '{0, 8'd0,  32'h0,        4'h0, 1, 8'h20, -1, 32'h0,    1, 32'h0,        0, 0, 32'h0, 0};
    tbl[10] = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,  -1, 32'h0,    1, 32'h0,        0, 1, 32'h0, 1};
    tbl[11] = '{1, 8'd4,  32'h1,        4'hF, 0, 8'd0,  -1, 32'h0,    4, 32'h1,        0, 0, 32'h0, 0};
    tbl[12] = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,  -1, 32'h0,    4, 32'h0,        0, 0, 32'h0, 0};
    tbl[13] = '{1, 8'd4,  32'h1,        4'hF, 0, 8'd0,  -1, 32'h0,    4, 32'h1,        0, 0, 32'h0, 0};
    tbl[14] = '{1, 8'd4,  32'h1,        4'hF, 0, 8'd0,  -1, 32'h0,    4, 32'h1,        0, 0, 32'h0, 0};
    tbl[15] = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,  -1, 32'h0,    4, 32'h0,        0, 0, 32'h0, 0};
    tbl[16] = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,   6, 32'hABCD, 6, 32'hABCD,     0, 0, 32'h0, 0};
    tbl[17] = '{1, 8'd6,  32'hFFFFFFFF, 4'hF, 0, 8'd0,  -1, 32'h0,    6, 32'hABCD,     1, 0, 32'h0, 0};
    tbl[18] = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,   8, 32'h0F,   8, 32'h0F,       0, 0, 32'h0, 0};
    tbl[19] = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,  -1, 32'h0,    8, 32'h0F,       0, 0, 32'h0, 0};
    tbl[20] = '{1, 8'd8,  32'h05,       4'hF, 0, 8'd0,  -1, 32'h0,    8, 32'h0A,       0, 0, 32'h0, 0};
    tbl[21] = '{1, 8'h10, 32'h1,        4'hF, 0, 8'd0,  -1, 32'h0,    0, 32'h0,        1, 0, 32'h0, 0};
    tbl[22] = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,   0, 32'h1234, 0, 32'h0,        0, 0, 32'h0, 0};
    tbl[23] = '{1, 8'd2,  32'h0,        4'hF, 1, 8'd2,  -1, 32'h0,    2, 32'h0,        0, 0, 32'h0, 0};
    tbl[24] = '{0, 8'd0,  32'h0,        4'h0, 0, 8'd0,  -1, 32'h0,    2, 32'h0,        0, 1, 32'h11BB33DD, 0};

    checks = 0; failures = 0; edge_n = 0; last_rv = '0; m_werr = 0; m_irq = 0;
    cap_first = 0; cap_last = 0;
    foreach (m_mem[k]) m_mem[k] = '0;
    clk = 0;
    idle();

    // reset with a write and a read pending
    rst_n = 0;
    bus.i_w_en = 1; bus.i_w_addr = 8'd2; bus.i_w_value = 32'h55AA55AA; bus.i_w_strobe = 4'hF;
    bus.i_r_en = 1; bus.i_r_addr = 8'd2; hw_set = 16'hFFFF; hw_value = '1;
    repeat (3) step();
    rst_n = 1;
    idle();
    step();

    // directed table
    foreach (tbl[i]) begin
      idle();
      bus.i_w_en = tbl[i].we; bus.i_w_addr = tbl[i].wa;
      bus.i_w_value = tbl[i].wv; bus.i_w_strobe = tbl[i].ws;
      bus.i_r_en = tbl[i].re; bus.i_r_addr = tbl[i].ra;
      if (tbl[i].hk >= 0) begin
        hw_set[tbl[i].hk] = 1'b1; hw_value[tbl[i].hk] = tbl[i].hv;
      end
      step();
      chk($sformatf("tbl%0d_mem", i), mem[tbl[i].ck], tbl[i].cv);
      chk($sformatf("tbl%0d_werr", i), bus.o_w_err, tbl[i].cwe);
      chk($sformatf("tbl%0d_rvalid", i), bus.o_r_valid, tbl[i].crv);
      if (tbl[i].crv) begin
        chk($sformatf("tbl%0d_rvalue", i), bus.o_r_value, tbl[i].crval);
        chk($sformatf("tbl%0d_rerr", i), bus.o_r_err, tbl[i].crerr);
      end
    end

    // pipeline: reads of regs 0..7 back to back, same-cycle write to reg 5
    for (int k = 0; k < 8; k++) begin
      idle();
      bus.i_w_en = 1; bus.i_w_addr = 8'(k); bus.i_w_value = 32'h100 + k; bus.i_w_strobe = 4'hF;
      step();
    end
    idle();
    step();
    step();
    cap.delete();
    for (int k = 0; k < 8; k++) begin
      idle();
      bus.i_r_en = 1; bus.i_r_addr = 8'(k);
      if (k == 5) begin
        bus.i_w_en = 1; bus.i_w_addr = 8'd5; bus.i_w_value = 32'hFFFFFFFF; bus.i_w_strobe = 4'hF;
      end
      step();
    end
    idle();
    repeat (3) step();
    chk("pipe_count", cap.size(), 8);
    chk("pipe_back_to_back", cap_last - cap_first + 1, 8);
    chk("pipe_reg5_old", (cap.size() > 5) ? cap[5] : 'x, 32'h105);
    chk("pipe_reg5_new", mem[5], 32'hFFFFFFFF);

    // read in flight when reset arrives must never return
    idle();
    bus.i_r_en = 1; bus.i_r_addr = 8'd0;
    step();
    cap.delete();
    idle();
    rst_n = 0;
    bus.i_w_en = 1; bus.i_w_addr = 8'd0; bus.i_w_value = 32'h77; bus.i_w_strobe = 4'hF;
    step();
    rst_n = 1;
    idle();
    repeat (3) step();
    chk("flush_no_valid", cap.size(), 0);

    // randomized run against the model
    for (int n = 0; n < 1500; n++) begin
      idle();
      rst_n = ($urandom_range(0, 199) != 0);
      bus.i_w_en = $urandom_range(0, 1);
      bus.i_w_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
      bus.i_w_value = $urandom;
      bus.i_w_strobe = 4'($urandom);
      bus.i_r_en = $urandom_range(0, 1);
      bus.i_r_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
      hw_set = 16'($urandom & $urandom & $urandom);
      for (int k = 0; k < D; k++) hw_value[k] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      step();
    end
    rst_n = 1;
    idle();
    nv = 0;
    repeat (LAT + 1) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
